// File: rtl/booth_sequencer.sv
// Sequential radix-2 Booth multiplier: one Booth step per clock, NR_BITS steps per product.
// state  | meaning
// S_IDLE | waiting for start, ready=1
// S_RUN  | Booth steps in progress, busy=1, inputs ignored
// S_DONE | product on out, done pulse; start here is accepted back-to-back
module booth_sequencer #(
  parameter int NR_BITS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NR_BITS-1:0]     M,
  input  logic [NR_BITS-1:0]     R,
  output logic                   ready,
  output logic                   busy,
  output logic                   done,
  output logic [2*NR_BITS-1:0]   out
);

  localparam int CW = $clog2(NR_BITS + 1);
  localparam int PW = 2 * NR_BITS + 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               r_state;
  logic                 r_ready;
  logic                 r_busy;
  logic                 r_done;
  logic [2*NR_BITS-1:0] r_out;
  logic [PW-1:0]        r_p;
  logic [NR_BITS-1:0]   r_m;
  logic [CW-1:0]        r_cnt;

  logic [NR_BITS:0]     w_head;
  logic [NR_BITS:0]     w_m_ext;
  logic [NR_BITS:0]     w_operand;
  logic [NR_BITS:0]     w_sum;
  logic [NR_BITS:0]     w_head_new;
  logic [PW-1:0]        w_p_next;
  logic                 w_sub;
  logic                 w_add_en;
  logic                 w_last;

  // Head and M are one bit wider than the operands so M = -2^(NR_BITS-1) cannot overflow.
  assign w_head     = r_p[PW-1:NR_BITS+1];
  assign w_m_ext    = {r_m[NR_BITS-1], r_m};
  assign w_sub      = (r_p[1:0] == 2'b10);
  assign w_add_en   = r_p[1] ^ r_p[0];
  assign w_operand  = w_sub ? ~w_m_ext : w_m_ext;
  assign w_sum      = w_head + w_operand + {{NR_BITS{1'b0}}, w_sub};
  assign w_head_new = w_add_en ? w_sum : w_head;
  assign w_p_next   = {w_head_new[NR_BITS], w_head_new, r_p[NR_BITS:1]};
  assign w_last     = (r_cnt == CW'(NR_BITS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_out   <= '0;
      r_p     <= '0;
      r_m     <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_RUN;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_m     <= M;
            r_p     <= {{(NR_BITS+1){1'b0}}, R, 1'b0};
            r_cnt   <= '0;
          end else begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        end
        S_RUN: begin
          r_p   <= w_p_next;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_state <= S_DONE;
            r_out   <= w_p_next[2*NR_BITS:1];
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign ready = r_ready;
  assign busy  = r_busy;
  assign done  = r_done;
  assign out   = r_out;

endmodule

// File: tb/tb_booth_sequencer.sv
// Directed and sweep bench for booth_sequencer at NR_BITS=4 and NR_BITS=8.
module tb_booth_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start;
  logic [3:0] m4, r4;
  logic       ready4, busy4, done4;
  logic [7:0] out4;

  logic        reset8, start8;
  logic [7:0]  m8, r8;
  logic        ready8, busy8, done8;
  logic [15:0] out8;

  int n_checks = 0;
  int n_fail   = 0;

  booth_sequencer #(.NR_BITS(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start), .M(m4), .R(r4),
    .ready(ready4), .busy(busy4), .done(done4), .out(out4)
  );

  booth_sequencer #(.NR_BITS(8)) u_dut8 (
    .clk(clk), .reset(reset8), .start(start8), .M(m8), .R(r8),
    .ready(ready8), .busy(busy8), .done(done8), .out(out8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref4(input logic [3:0] m, input logic [3:0] r);
    int a, b;
    a = $signed(m);
    b = $signed(r);
    return 8'(a * b);
  endfunction

  function automatic logic [15:0] ref8(input logic [7:0] m, input logic [7:0] r);
    int a, b;
    a = $signed(m);
    b = $signed(r);
    return 16'(a * b);
  endfunction

  // Starts one product from IDLE; lat = edges after the accepting edge until done is seen.
  task automatic run4(input logic [3:0] m, input logic [3:0] r,
                      output logic [7:0] res, output int lat);
    m4 = m; r4 = r; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (done4 !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    res = out4;
    tick();
  endtask

  task automatic run8(input logic [7:0] m, input logic [7:0] r,
                      output logic [15:0] res, output int lat);
    m8 = m; r8 = r; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    lat = 0;
    while (done8 !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    res = out8;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  res;
    logic [15:0] res16;
    logic [7:0]  ra, rb;
    int lat, cnt, bad_lat;

    reset = 1'b1; start = 1'b0; m4 = '0; r4 = '0;
    reset8 = 1'b1; start8 = 1'b0; m8 = '0; r8 = '0;
    tick();
    tick();
    reset = 1'b0; reset8 = 1'b0;
    chk("rst_ready", ready4, 1);
    chk("rst_busy",  busy4,  0);
    chk("rst_done",  done4,  0);
    chk("rst_out",   out4,   0);
    chk("rst_out8",  out8,   0);

    // 3*5: busy for 4 cycles then a single done pulse
    m4 = 4'd3; r4 = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    chk("run_ready", ready4, 0);
    cnt = 0;
    while (busy4 === 1'b1 && cnt < 20) begin
      cnt++;
      tick();
    end
    chk("busy_cycles", cnt, 4);
    chk("done_pulse", done4, 1);
    chk("out_3x5", out4, 8'h0F);
    chk("done_ready", ready4, 1);
    tick();
    chk("done_one_cycle", done4, 0);
    chk("idle_ready", ready4, 1);

    run4(4'hD, 4'd5, res, lat);
    chk("out_m3x5", res, 8'hF1);
    chk("lat_m3x5", lat, 4);
    run4(4'h8, 4'h8, res, lat);
    chk("out_m8xm8", res, 8'h40);
    run4(4'h8, 4'd7, res, lat);
    chk("out_m8x7", res, 8'hC8);

    // start while busy is ignored
    m4 = 4'd3; r4 = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    m4 = 4'd2; r4 = 4'd3; start = 1'b1;
    tick();
    start = 1'b0; m4 = '0; r4 = '0;
    lat = 2;
    while (done4 !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    chk("busy_start_lat", lat, 4);
    chk("busy_start_out", out4, 8'h0F);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done4 === 1'b1) cnt++;
    end
    chk("busy_start_no_extra_done", cnt, 0);
    chk("busy_start_out_hold", out4, 8'h0F);

    // start held high: back-to-back (1,1) then (2,2)
    m4 = 4'd1; r4 = 4'd1; start = 1'b1;
    tick();
    lat = 0;
    while (done4 !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    chk("b2b_first_lat", lat, 4);
    chk("b2b_first_out", out4, 8'h01);
    m4 = 4'd2; r4 = 4'd2;
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (done4 !== 1'b1 && cnt < 20);
    chk("b2b_gap", cnt, 5);
    chk("b2b_second_out", out4, 8'h04);
    start = 1'b0;
    tick();
    chk("b2b_idle_ready", ready4, 1);
    chk("b2b_idle_busy", busy4, 0);

    // reset on the second RUN cycle of 7*7
    m4 = 4'd7; r4 = 4'd7; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_ready", ready4, 1);
    chk("abort_busy", busy4, 0);
    chk("abort_done", done4, 0);
    chk("abort_out", out4, 8'h00);
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (done4 === 1'b1) cnt++;
    end
    chk("abort_no_done", cnt, 0);
    run4(4'd7, 4'd7, res, lat);
    chk("after_abort_7x7", res, 8'h31);

    bad_lat = 0;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        run4(4'(i), 4'(j), res, lat);
        if (lat != 4) bad_lat++;
        chk($sformatf("sweep4_%0d_%0d", i, j), res, ref4(4'(i), 4'(j)));
      end
    end
    chk("sweep4_latency_errors", bad_lat, 0);

    bad_lat = 0;
    run8(8'h80, 8'h80, res16, lat);
    chk("w8_m128xm128", res16, 16'h4000);
    run8(8'h7F, 8'h80, res16, lat);
    chk("w8_127xm128", res16, 16'hC080);
    chk("w8_latency", lat, 8);
    for (int k = 0; k < 100; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      run8(ra, rb, res16, lat);
      if (lat != 8) bad_lat++;
      chk($sformatf("rand8_%0h_%0h", ra, rb), res16, ref8(ra, rb));
    end
    chk("rand8_latency_errors", bad_lat, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
